// File: rtl/noc_local_arbiter.sv
// noc_local_arbiter: packet-atomic round-robin arbiter that shares one
// NoC local injection port among N_REQ requesters.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   i_req_data          flit of requester k at [k*FLIT_W +: FLIT_W]
//   i_req_valid/_last   per-requester valid and end-of-packet
//   o_req_ready         per-requester flit consumed this cycle
//   o_sdata, o_svalid   flit and credit-qualified valid to router
//   i_scredit           router local input can take a flit
//   o_grant, o_busy     one-hot owner, packet in progress
//   o_pkt_count         completed packets, wraps at 16 bits
//   o_timeout_err       sticky stall error
//
// Optional: define NOC_ARB_TIMEOUT_EN to release a stalled owner after
// TIMEOUT cycles without a valid flit; otherwise o_timeout_err is 0.

module noc_local_arbiter #(
    parameter int N_REQ   = 4,
    parameter int FLIT_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ*FLIT_W-1:0]   i_req_data,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ-1:0]          i_req_last,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic [FLIT_W-1:0]         o_sdata,
    output logic                      o_svalid,
    input  logic                      i_scredit,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_busy,
    output logic [15:0]               o_pkt_count,
    output logic                      o_timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;

    logic               in_grant;
    logic               own_valid;
    logic               own_last;
    logic               xfer;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               expire;

    assign in_grant  = (state_q == GRANT);
    assign own_valid = i_req_valid[owner_q];
    assign own_last  = i_req_last[owner_q];
    // Credit is the router's ready: a flit moves only when both agree.
    assign xfer      = in_grant & own_valid & i_scredit;

    // Search starts one past the last winner so the previous owner
    // is considered last.
    always_comb begin : pick
        logic [IDX_W-1:0] cand;
        int               j;
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = '0;
        j          = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = IDX_W'(j);
            if (!pick_found && i_req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef NOC_ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

    logic [7:0] stall_q, stall_d;
    logic       err_q, err_d;
    logic       stall;

    // Only owner starvation counts; credit back-pressure is the router's.
    assign stall  = in_grant & ~own_valid & i_scredit;
    assign expire = stall & (stall_q == STALL_LAST);

    always_comb begin
        stall_d = stall_q;
        err_d   = err_q;
        if (!in_grant || xfer) begin
            stall_d = '0;
        end else if (stall) begin
            stall_d = stall_q + 8'd1;
        end
        if (expire) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign o_timeout_err = err_q;
`else
    assign expire        = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = GRANT;
                    grant_d  = N_REQ'(1) << pick_idx;
                    owner_d  = pick_idx;
                    rr_ptr_d = pick_idx;
                end
            end
            GRANT: begin
                if (xfer && own_last) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end else if (expire) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= IDX_W'(N_REQ - 1);
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign o_busy      = in_grant;
    assign o_grant     = grant_q;
    assign o_svalid    = xfer;
    assign o_req_ready = xfer ? grant_q : '0;
    assign o_sdata     = in_grant ? i_req_data[owner_q*FLIT_W +: FLIT_W]
                                  : '0;
    assign o_pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_noc_local_arbiter.sv
// tb_noc_local_arbiter: directed scoreboard bench for noc_local_arbiter.
// Expected flits are queued in predicted grant order and popped on o_svalid.

module tb_noc_local_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req_data;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [3:0]  o_req_ready;
    logic [15:0] o_sdata;
    logic        o_svalid;
    logic        scredit;
    logic [3:0]  o_grant;
    logic        o_busy;
    logic [15:0] o_pkt_count;
    logic        o_timeout_err;

    always #5 clk = ~clk;

    noc_local_arbiter #(
        .N_REQ  (4),
        .FLIT_W (16),
        .TIMEOUT(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_data   (req_data),
        .i_req_valid  (valid),
        .i_req_last   (last),
        .o_req_ready  (o_req_ready),
        .o_sdata      (o_sdata),
        .o_svalid     (o_svalid),
        .i_scredit    (scredit),
        .o_grant      (o_grant),
        .o_busy       (o_busy),
        .o_pkt_count  (o_pkt_count),
        .o_timeout_err(o_timeout_err)
    );

    typedef struct {
        logic [3:0]  g;
        logic [15:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [16:0] rq[4][$];
    logic [3:0]  en;
    logic        credit;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc;
    int          first_sv;
    int          last_sv;
    int          nsv;
    int          exp_pkt;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int k, input logic [15:0] base,
                        input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            rq[k].push_back({(i == n - 1), base + 16'(i)});
            e.g = 4'(1 << k);
            e.d = base + 16'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive();
        logic [16:0] h;
        for (int k = 0; k < 4; k++) begin
            if (en[k] && rq[k].size() > 0) begin
                h = rq[k][0];
                valid[k] = 1'b1;
                last[k]  = h[16];
                req_data[k*16 +: 16] = h[15:0];
            end else begin
                valid[k] = 1'b0;
                last[k]  = 1'b0;
                req_data[k*16 +: 16] = 16'h0;
            end
        end
        scredit = credit;
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        chk("svalid_no_credit", {63'b0, o_svalid & ~scredit}, 64'd0);
        if (o_svalid) begin
            if (first_sv < 0) first_sv = cyc;
            last_sv = cyc;
            nsv++;
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL flit_unexpected: observed %0h none queued",
                       o_sdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("flit", {44'b0, o_grant, o_sdata}, {44'b0, e.g, e.d});
                chk("ready", {60'b0, o_req_ready}, {60'b0, e.g});
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (o_req_ready[k] && rq[k].size() > 0) begin
                void'(rq[k].pop_front());
            end
        end
        cyc++;
    endtask

    task automatic clr_stats();
        cyc      = 0;
        first_sv = -1;
        last_sv  = -1;
        nsv      = 0;
    endtask

    task automatic run(input int budget);
        int n;
        clr_stats();
        n = 0;
        do begin
            cycle();
            n++;
        end while ((exp_q.size() != 0 || o_busy) && n < budget);
        n_checks++;
        assert (exp_q.size() == 0 && !o_busy) else begin
            n_errors++;
            $error("FAIL run_done: observed %0d pending expected 0",
                   exp_q.size());
        end
    endtask

    initial begin
        int cnt;
        exp_t e;
        rst      = 1'b0;
        credit   = 1'b1;
        scredit  = 1'b1;
        en       = 4'hF;
        valid    = '0;
        last     = '0;
        req_data = '0;
        exp_pkt  = 0;
        #3;
        chk("rst_grant", {60'b0, o_grant}, 64'd0);
        chk("rst_svalid", {63'b0, o_svalid}, 64'd0);
        chk("rst_ready", {60'b0, o_req_ready}, 64'd0);
        chk("rst_busy", {63'b0, o_busy}, 64'd0);
        chk("rst_pkt", {48'b0, o_pkt_count}, 64'd0);
        chk("rst_err", {63'b0, o_timeout_err}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // 3-flit packet from req0
        send(0, 16'h1101, 3);
        run(20);
        exp_pkt = 1;
        chk("t1_first", 64'(first_sv), 64'd1);
        chk("t1_last", 64'(last_sv), 64'd3);
        chk("t1_nsv", 64'(nsv), 64'd3);
        chk("t1_pkt", {48'b0, o_pkt_count}, 64'(exp_pkt));
        chk("t1_grant", {60'b0, o_grant}, 64'd0);

        // req1 and req3 together: req1 first, one bubble, then req3
        send(1, 16'h2101, 2);
        send(3, 16'h4101, 2);
        run(30);
        exp_pkt += 2;
        chk("t2_first", 64'(first_sv), 64'd1);
        chk("t2_last", 64'(last_sv), 64'd5);
        chk("t2_pkt", {48'b0, o_pkt_count}, 64'(exp_pkt));

        // credit withheld mid-packet for 5 cycles
        send(2, 16'h3101, 4);
        clr_stats();
        repeat (3) cycle();
        credit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_svalid", {63'b0, o_svalid}, 64'd0);
            chk("t3_ready", {60'b0, o_req_ready}, 64'd0);
            chk("t3_grant", {60'b0, o_grant}, 64'd4);
        end
        credit = 1'b1;
        run(30);
        exp_pkt += 1;
        chk("t3_nsv", 64'(nsv), 64'd2);
        chk("t3_pkt", {48'b0, o_pkt_count}, 64'(exp_pkt));

        // 16 single-flit packets, rotation continues after req2
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                send((3 + j) % 4, 16'h5000 + 16'(r * 16 + ((3 + j) % 4)), 1);
            end
        end
        run(100);
        exp_pkt += 16;
        chk("t4_nsv", 64'(nsv), 64'd16);
        chk("t4_last", 64'(last_sv), 64'd31);
        chk("t4_pkt", {48'b0, o_pkt_count}, 64'(exp_pkt));

        // async reset after the first of three flits
        send(0, 16'h6101, 3);
        clr_stats();
        repeat (2) cycle();
        @(posedge clk);
        #1 drive();
        #1;
        chk("t5_pre_svalid", {63'b0, o_svalid}, 64'd1);
        rst = 1'b0;
        #1;
        chk("t5_svalid", {63'b0, o_svalid}, 64'd0);
        chk("t5_grant", {60'b0, o_grant}, 64'd0);
        chk("t5_busy", {63'b0, o_busy}, 64'd0);
        chk("t5_pkt", {48'b0, o_pkt_count}, 64'd0);
        rq[0].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send(0, 16'h6101, 3);
        send(1, 16'h7101, 1);
        run(30);
        exp_pkt = 2;
        chk("t5_after_pkt", {48'b0, o_pkt_count}, 64'(exp_pkt));

        // owner req2 stops presenting after one flit; req3 waits
        rq[2].push_back({1'b0, 16'h8101});
        rq[2].push_back({1'b1, 16'h8102});
        rq[3].push_back({1'b1, 16'h9101});
        e.g = 4'b0100;
        e.d = 16'h8101;
        exp_q.push_back(e);
`ifdef NOC_ARB_TIMEOUT_EN
        e.g = 4'b1000;
        e.d = 16'h9101;
        exp_q.push_back(e);
        repeat (2) cycle();
        en[2] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (!o_busy) break;
            cnt++;
        end
        chk("t6_stall_cycles", 64'(cnt), 64'd10);
        chk("t6_err", {63'b0, o_timeout_err}, 64'd1);
        chk("t6_pkt", {48'b0, o_pkt_count}, 64'(exp_pkt));
        run(20);
        exp_pkt += 1;
        chk("t6_err_sticky", {63'b0, o_timeout_err}, 64'd1);
        chk("t6_next_pkt", {48'b0, o_pkt_count}, 64'(exp_pkt));
        rq[2].delete();
        en[2] = 1'b1;
`else
        e.d = 16'h8102;
        exp_q.push_back(e);
        e.g = 4'b1000;
        e.d = 16'h9101;
        exp_q.push_back(e);
        repeat (2) cycle();
        en[2] = 1'b0;
        cnt = 0;
        repeat (20) cycle();
        chk("t6_busy_held", {63'b0, o_busy}, 64'd1);
        chk("t6_grant_held", {60'b0, o_grant}, 64'd4);
        chk("t6_err", {63'b0, o_timeout_err}, 64'd0);
        en[2] = 1'b1;
        run(20);
        exp_pkt += 2;
        chk("t6_pkt", {48'b0, o_pkt_count}, 64'(exp_pkt));
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
